// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared arbiter state encodings
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_GNT_D, ARB_GNT_F, ARB_RESP} arb_state_t;
endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// arb_wait_timer: counts wait states and flags the cycle that reaches TIMEOUT
module arb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt;
  assign tc = (TIMEOUT != 0) && en && (cnt == CW'(TIMEOUT - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en) cnt <= cnt + CW'(1);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, data first with bounded fetch starvation
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_DATA_RUN = 4,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_done,
  output logic            if_err,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic [DW-1:0]   d_rdata,
  output logic            d_done,
  output logic            d_err,
  output logic            m_req,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_be,
  input  logic [DW-1:0]   m_rdata,
  input  logic            m_ready,
  output logic            arb_busy
);
  localparam int RW = $clog2(MAX_DATA_RUN + 1);
  arb_state_t state, next;
  logic [RW-1:0] run_cnt;
  logic sel_f, err_q, tc, gnt_d, gnt_f, end_acc;
  logic [DW-1:0] cap;
  assign m_req    = state == ARB_GNT_D || state == ARB_GNT_F;
  assign arb_busy = state != ARB_IDLE;
  assign if_done  = state == ARB_RESP && sel_f;
  assign d_done   = state == ARB_RESP && !sel_f;
  assign if_err   = if_done && err_q;
  assign d_err    = d_done && err_q;
  assign gnt_d    = state == ARB_IDLE && d_req && !(if_req && run_cnt == RW'(MAX_DATA_RUN));
  assign gnt_f    = state == ARB_IDLE && !gnt_d && if_req;
  assign end_acc  = m_req && (m_ready || tc);
  assign cap      = m_ready && !m_we ? m_rdata : '0;
  arb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk), .rst(rst), .clear(!m_req), .en(m_req && !m_ready), .tc(tc)
  );
  always_comb
    next = state == ARB_IDLE ? (gnt_d ? ARB_GNT_D : gnt_f ? ARB_GNT_F : ARB_IDLE) :
           state == ARB_RESP ? ARB_IDLE : end_acc ? ARB_RESP : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= ARB_IDLE;
      run_cnt  <= '0;
      sel_f    <= 1'b0;
      err_q    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_be     <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      state <= next;
      if (gnt_d) begin
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
        m_be    <= d_be;
        sel_f   <= 1'b0;
        run_cnt <= if_req ? (run_cnt == RW'(MAX_DATA_RUN) ? run_cnt : run_cnt + RW'(1)) : '0;
      end else if (gnt_f) begin
        m_we    <= 1'b0;
        m_addr  <= if_addr;
        m_wdata <= '0;
        m_be    <= '1;
        sel_f   <= 1'b1;
        run_cnt <= '0;
      end
      if (end_acc) begin
        err_q <= !m_ready;
        if (sel_f) if_rdata <= cap;
        else d_rdata <= cap;
      end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus multi-cycle corner sequences
module tb_mem_port_arbiter;
  logic clk = 0, rst = 1;
  logic if_req = 0, d_req = 0, d_we = 0, m_ready = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
  logic [3:0] d_be = 0;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0] m_be;
  logic if_done, if_err, d_done, d_err, m_req, m_we, arb_busy;
  int tests = 0, fails = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_DATA_RUN(2), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_err(if_err), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_be(d_be), .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_rdata(m_rdata), .m_ready(m_ready), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] mem;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t v[4];
  logic [31:0] last_if, last_d;

  initial begin
    v[0] = '{1'b0, 1'b0, 32'h100,      32'h0,    4'h0, 32'hDEADBEEF, 4'hF, 32'h0,    32'hDEADBEEF};
    v[1] = '{1'b1, 1'b1, 32'h2000,     32'h55AA, 4'hF, 32'hFFFFFFFF, 4'hF, 32'h55AA, 32'h0};
    v[2] = '{1'b1, 1'b0, 32'h40,       32'h9999, 4'h3, 32'h12345678, 4'h3, 32'h9999, 32'h12345678};
    v[3] = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'h0,    4'h0, 32'hA5A5A5A5, 4'hF, 32'h0,    32'hA5A5A5A5};

    // reset with random inputs
    if_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom); m_ready = 1'($urandom);
    if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; m_rdata = $urandom; d_be = 4'($urandom);
    step;
    chk("rst m_req", m_req, 0);
    chk("rst busy", arb_busy, 0);
    chk("rst dones", {if_done, d_done, if_err, d_err}, 0);
    chk("rst m_attr", {m_we, m_addr, m_be}, 0);
    chk("rst m_wdata", m_wdata, 0);
    chk("rst rdata", {if_rdata, d_rdata}, 0);
    if_req = 0; d_req = 0; d_we = 0; m_ready = 1;
    step;
    rst = 0;
    step;
    last_if = 0; last_d = 0;

    for (int i = 0; i < 4; i++) begin
      if_req = !v[i].is_d; d_req = v[i].is_d;
      if_addr = v[i].addr; d_addr = v[i].addr; d_we = v[i].we;
      d_wdata = v[i].wdata; d_be = v[i].be; m_rdata = v[i].mem;
      chk($sformatf("v%0d idle m_req", i), m_req, 0);
      step;
      chk($sformatf("v%0d m_req", i), {m_req, arb_busy}, 2'b11);
      chk($sformatf("v%0d m_addr", i), m_addr, v[i].addr);
      chk($sformatf("v%0d m_we", i), m_we, v[i].we);
      chk($sformatf("v%0d m_be", i), m_be, v[i].exp_be);
      if (v[i].we) chk($sformatf("v%0d m_wdata", i), m_wdata, v[i].exp_wdata);
      chk($sformatf("v%0d early done", i), {if_done, d_done}, 0);
      step;
      chk($sformatf("v%0d done", i), {if_done, d_done, if_err, d_err}, {!v[i].is_d, v[i].is_d, 2'b00});
      chk($sformatf("v%0d resp m_req", i), m_req, 0);
      if (v[i].is_d) last_d = v[i].exp_rdata; else last_if = v[i].exp_rdata;
      chk($sformatf("v%0d if_rdata", i), if_rdata, last_if);
      chk($sformatf("v%0d d_rdata", i), d_rdata, last_d);
      if_req = 0; d_req = 0;
      step;
      chk($sformatf("v%0d back idle", i), arb_busy, 0);
    end

    // timeout: m_ready never comes
    begin
      int hi = 0;
      bit seen = 0;
      m_ready = 0; d_req = 1; d_we = 0; d_addr = 32'h80;
      for (int c = 0; c < 12 && !seen; c++) begin
        step;
        if (m_req) hi++;
        if (d_done) begin
          seen = 1;
          chk("to d_err", {d_err, if_done, if_err}, 3'b100);
          chk("to d_rdata", d_rdata, 0);
          chk("to m_req at done", m_req, 0);
          d_req = 0;
        end
      end
      chk("to seen done", seen, 1);
      chk("to m_req cycles", hi, 4);
      step;
    end

    // simultaneous requests: data first, fetch granted 3 cycles later
    m_ready = 1; m_rdata = 32'h77;
    if_req = 1; if_addr = 32'h300; d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'h55AA; d_be = 4'hF;
    step;
    chk("both m_addr", m_addr, 32'h2000);
    chk("both m_we", m_we, 1);
    step;
    chk("both d_done", {d_done, if_done}, 2'b10);
    d_req = 0;
    step;
    chk("both idle gap", {m_req, arb_busy}, 0);
    step;
    chk("both f m_req", m_req, 1);
    chk("both f m_addr", m_addr, 32'h300);
    chk("both f m_we", m_we, 0);
    step;
    chk("both if_done", {if_done, if_rdata}, {1'b1, 32'h77});
    if_req = 0;
    step;

    // run limit: D,D,F,D,D,F
    begin
      logic [31:0] order[6] = '{32'hD000, 32'hD000, 32'hF000, 32'hD000, 32'hD000, 32'hF000};
      if_req = 1; if_addr = 32'hF000; d_req = 1; d_we = 0; d_addr = 32'hD000;
      for (int g = 0; g < 6; g++) begin
        int w = 0;
        do begin step; w++; end while (!m_req && w < 8);
        chk($sformatf("run grant%0d", g), m_addr, order[g]);
        step;
        if (g == 5) begin if_req = 0; d_req = 0; end
        step;
      end
    end

    // reset in the middle of a waited fetch
    begin
      bit got = 0;
      m_ready = 0; if_req = 1; if_addr = 32'h500;
      step; step; step;
      chk("mid m_req before rst", m_req, 1);
      rst = 1;
      #1;
      chk("mid m_req at rst", {m_req, arb_busy}, 0);
      if_req = 0; m_ready = 1;
      step;
      rst = 0;
      for (int c = 0; c < 6; c++) begin
        step;
        if (if_done || m_req) got = 1;
      end
      chk("mid no done", got, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
